// File: rtl/game_link_decoder.sv
// Parses 5-byte link frames (A5, TYPE, HI, LO, CHK) from a UART byte stream and
// keeps the link-alive flag, the last keeper/shot positions and a frame error count.
module game_link_decoder #(
  parameter int POS_W          = 12,
  parameter int TIMEOUT_CYCLES = 65_000_000,
  parameter int GAP_CYCLES     = 6_500
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             connect_corrected,
  output logic [POS_W-1:0] keeper_pos,
  output logic [POS_W-1:0] shot_pos,
  output logic             frame_ok,
  output logic             ack_req,
  output logic [7:0]       err_cnt
);

  localparam int ALIVE_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int GAP_W   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [ALIVE_W-1:0] ALIVE_LAST = ALIVE_W'(TIMEOUT_CYCLES - 1);
  localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'(GAP_CYCLES - 1);

  localparam logic [7:0] HDR       = 8'hA5;
  localparam logic [7:0] T_CONNECT = 8'h01;
  localparam logic [7:0] T_KEEPER  = 8'h02;
  localparam logic [7:0] T_SHOT    = 8'h03;

  typedef enum logic [2:0] {S_IDLE, S_TYPE, S_HI, S_LO, S_CHK} state_t;

  state_t             state, state_next;
  logic [7:0]         type_q, hi_q, lo_q;
  logic [GAP_W-1:0]   gap_cnt;
  logic [ALIVE_W-1:0] alive_cnt;

  logic latch_type, latch_hi, latch_lo;
  logic commit, err_event, gap_timeout;

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_next;
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_next  = state;
    latch_type  = 1'b0;
    latch_hi    = 1'b0;
    latch_lo    = 1'b0;
    commit      = 1'b0;
    err_event   = 1'b0;
    gap_timeout = 1'b0;
    if (rx_valid) begin
      case (state)
        S_IDLE: if (rx_data == HDR) state_next = S_TYPE;
        S_TYPE: begin
          if (rx_data inside {T_CONNECT, T_KEEPER, T_SHOT}) begin
            latch_type = 1'b1;
            state_next = S_HI;
          end else begin
            err_event  = 1'b1;
            state_next = S_IDLE;
          end
        end
        // A5 inside the payload is plain data; there is no mid-frame resync.
        S_HI: begin
          latch_hi   = 1'b1;
          state_next = S_LO;
        end
        S_LO: begin
          latch_lo   = 1'b1;
          state_next = S_CHK;
        end
        S_CHK: begin
          state_next = S_IDLE;
          if (rx_data == (type_q ^ hi_q ^ lo_q)) commit    = 1'b1;
          else                                   err_event = 1'b1;
        end
        default: state_next = S_IDLE;
      endcase
    end else if (state != S_IDLE && gap_cnt == GAP_LAST) begin
      gap_timeout = 1'b1;
      err_event   = 1'b1;
      state_next  = S_IDLE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      type_q            <= '0;
      hi_q              <= '0;
      lo_q              <= '0;
      gap_cnt           <= '0;
      alive_cnt         <= '0;
      connect_corrected <= 1'b0;
      keeper_pos        <= '0;
      shot_pos          <= '0;
      frame_ok          <= 1'b0;
      ack_req           <= 1'b0;
      err_cnt           <= '0;
    end else begin
      frame_ok <= commit;
      ack_req  <= commit && (type_q == T_CONNECT);

      if (latch_type) type_q <= rx_data;
      if (latch_hi)   hi_q   <= rx_data;
      if (latch_lo)   lo_q   <= rx_data;

      if (rx_valid || gap_timeout || state == S_IDLE) gap_cnt <= '0;
      else                                           gap_cnt <= gap_cnt + 1'b1;

      if (err_event && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;

      if (commit && type_q == T_KEEPER) keeper_pos <= POS_W'({hi_q, lo_q});
      if (commit && type_q == T_SHOT)   shot_pos   <= POS_W'({hi_q, lo_q});

      // A commit always wins over an expiring alive window.
      if (commit) begin
        alive_cnt <= '0;
        if (type_q == T_CONNECT) connect_corrected <= 1'b1;
      end else if (connect_corrected) begin
        if (alive_cnt == ALIVE_LAST) begin
          connect_corrected <= 1'b0;
          alive_cnt         <= '0;
        end else begin
          alive_cnt <= alive_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_game_link_decoder.sv
// Directed bench for game_link_decoder: a frame table plus hand-written sequences
// for alive timeout, inter-byte gap, reset mid-frame and error saturation.
module tb_game_link_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        connect_corrected;
  logic [11:0] keeper_pos;
  logic [11:0] shot_pos;
  logic        frame_ok;
  logic        ack_req;
  logic [7:0]  err_cnt;

  int checks = 0;
  int errors = 0;

  game_link_decoder #(
    .POS_W(12),
    .TIMEOUT_CYCLES(100),
    .GAP_CYCLES(10)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .connect_corrected(connect_corrected),
    .keeper_pos(keeper_pos),
    .shot_pos(shot_pos),
    .frame_ok(frame_ok),
    .ack_req(ack_req),
    .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          n;
    logic [47:0] b;       // first byte in [47:40]
    logic        conn;
    logic        ok;
    logic        ack;
    logic [11:0] keeper;
    logic [11:0] shot;
    logic [7:0]  err;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Bytes go out back-to-back; returns at the cycle where a commit becomes visible.
  task automatic send(input int n, input logic [47:0] b);
    for (int i = 0; i < n; i++) begin
      rx_data  = b[47-8*i -: 8];
      rx_valid = 1'b1;
      step(1);
    end
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic check_outs(input string tag, input logic conn, input logic ok, input logic ack,
                            input logic [11:0] keeper, input logic [11:0] shot, input logic [7:0] err);
    check({tag, "_conn"},   32'(connect_corrected), 32'(conn));
    check({tag, "_ok"},     32'(frame_ok),          32'(ok));
    check({tag, "_ack"},    32'(ack_req),           32'(ack));
    check({tag, "_keeper"}, 32'(keeper_pos),        32'(keeper));
    check({tag, "_shot"},   32'(shot_pos),          32'(shot));
    check({tag, "_err"},    32'(err_cnt),           32'(err));
  endtask

  initial begin
    vecs[0] = '{5, 48'hA5_01_00_00_01_00, 1'b1, 1'b1, 1'b1, 12'h000, 12'h000, 8'd0};
    vecs[1] = '{5, 48'hA5_02_01_2C_2F_00, 1'b1, 1'b1, 1'b0, 12'h12C, 12'h000, 8'd0};
    vecs[2] = '{5, 48'hA5_03_01_2C_00_00, 1'b1, 1'b0, 1'b0, 12'h12C, 12'h000, 8'd1};
    vecs[3] = '{2, 48'hA5_07_00_00_00_00, 1'b1, 1'b0, 1'b0, 12'h12C, 12'h000, 8'd2};
    vecs[4] = '{5, 48'hA5_03_0A_BC_B5_00, 1'b1, 1'b1, 1'b0, 12'h12C, 12'hABC, 8'd2};
    vecs[5] = '{6, 48'h5A_A5_02_F1_23_D0, 1'b1, 1'b1, 1'b0, 12'h123, 12'hABC, 8'd2};
    vecs[6] = '{5, 48'hA5_02_A5_A5_02_00, 1'b1, 1'b1, 1'b0, 12'h5A5, 12'hABC, 8'd2};
    vecs[7] = '{2, 48'hA5_00_00_00_00_00, 1'b1, 1'b0, 1'b0, 12'h5A5, 12'hABC, 8'd3};
    vecs[8] = '{2, 48'hA5_A5_00_00_00_00, 1'b1, 1'b0, 1'b0, 12'h5A5, 12'hABC, 8'd4};
    vecs[9] = '{5, 48'hA5_01_FF_FF_01_00, 1'b1, 1'b1, 1'b1, 12'h5A5, 12'hABC, 8'd4};

    step(3);
    check_outs("reset", 1'b0, 1'b0, 1'b0, 12'h000, 12'h000, 8'd0);
    rst = 1'b1;
    step(1);

    for (int i = 0; i < 10; i++) begin
      send(vecs[i].n, vecs[i].b);
      check_outs($sformatf("v%0d", i), vecs[i].conn, vecs[i].ok, vecs[i].ack,
                 vecs[i].keeper, vecs[i].shot, vecs[i].err);
    end

    // Pulses last exactly one cycle.
    step(1);
    check("pulse_ok_drop",  32'(frame_ok), 32'd0);
    check("pulse_ack_drop", 32'(ack_req),  32'd0);

    // Alive window: drops exactly 100 cycles after the commit-visible cycle.
    send(5, 48'hA5_01_00_00_01_00);
    check("to_conn_c0", 32'(connect_corrected), 32'd1);
    step(99);
    check("to_conn_c99", 32'(connect_corrected), 32'd1);
    step(1);
    check("to_conn_c100", 32'(connect_corrected), 32'd0);
    check("to_keeper_hold", 32'(keeper_pos), 32'h5A5);
    check("to_shot_hold",   32'(shot_pos),   32'hABC);

    // KEEPER while disconnected updates position only.
    send(5, 48'hA5_02_03_21_20_00);
    check_outs("disc_keeper", 1'b0, 1'b1, 1'b0, 12'h321, 12'hABC, 8'd4);

    // Commit lands on the same edge as the alive expiry: commit wins.
    send(5, 48'hA5_01_00_00_01_00);
    step(95);
    send(5, 48'hA5_02_00_77_75_00);
    check_outs("coinc", 1'b1, 1'b1, 1'b0, 12'h077, 12'hABC, 8'd4);
    step(99);
    check("coinc_c99", 32'(connect_corrected), 32'd1);
    step(1);
    check("coinc_c100", 32'(connect_corrected), 32'd0);

    // Inter-byte gap: ten idle cycles abort the frame with one error.
    send(2, 48'hA5_02_00_00_00_00);
    step(9);
    check("gap_err_before", 32'(err_cnt), 32'd4);
    step(1);
    check("gap_err_after", 32'(err_cnt), 32'd5);
    step(3);
    check("gap_err_once", 32'(err_cnt), 32'd5);
    send(5, 48'hA5_02_00_05_07_00);
    check_outs("gap_next", 1'b0, 1'b1, 1'b0, 12'h005, 12'hABC, 8'd5);

    // Byte arriving on the gap-expiry cycle is processed normally.
    send(1, 48'hA5_00_00_00_00_00);
    step(9);
    send(4, 48'h02_00_06_04_00_00);
    check_outs("gap_coinc", 1'b0, 1'b1, 1'b0, 12'h006, 12'hABC, 8'd5);

    // Reset while in LO abandons the frame.
    send(3, 48'hA5_02_01_00_00_00);
    rst = 1'b0;
    step(1);
    check_outs("rst_mid", 1'b0, 1'b0, 1'b0, 12'h000, 12'h000, 8'd0);
    rst = 1'b1;
    send(5, 48'hA5_02_00_42_40_00);
    check_outs("rst_next", 1'b0, 1'b1, 1'b0, 12'h042, 12'h000, 8'd0);

    // Error counter saturates.
    for (int i = 0; i < 300; i++) begin
      send(5, 48'hA5_03_00_00_01_00);
      if (i == 254) check("sat_255", 32'(err_cnt), 32'd255);
    end
    check_outs("sat_300", 1'b0, 1'b0, 1'b0, 12'h042, 12'h000, 8'd255);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/game_link_decoder.md
GAME_LINK_DECODER -- requirements
Module: game_link_decoder

Interface
REQ-001 The block SHALL have parameter POS_W, default 12: width of decoded position outputs, legal range 1..16.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 65_000_000: link-alive window after the last valid frame.
REQ-003 The block SHALL have parameter GAP_CYCLES, default 6_500: maximum idle cycles between bytes of one frame.
REQ-004 Ports SHALL be:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-low reset.
- rx_data  in  8  received byte from the UART receiver.
- rx_valid  in  1  one-cycle strobe; rx_data is valid this cycle.
- connect_corrected  out  1  peer link alive.
- keeper_pos  out  POS_W  last valid keeper position.
- shot_pos  out  POS_W  last valid shot position.
- frame_ok  out  1  one-cycle pulse per committed frame.
- ack_req  out  1  one-cycle pulse on a committed CONNECT frame; requests a TX handshake reply.
- err_cnt  out  8  saturating count of frame errors.

Function
REQ-005 Frame format SHALL be: header 0xA5, TYPE, HI, LO, CHK; CHK = TYPE ^ HI ^ LO.
REQ-006 Types SHALL be 0x01 CONNECT, 0x02 KEEPER, 0x03 SHOT; all other types are invalid.
REQ-007 The FSM SHALL have states IDLE, TYPE, HI, LO, CHK; each state advances only on a cycle with rx_valid=1.
REQ-008 In IDLE, a byte equal to 0xA5 SHALL move the FSM to TYPE; any other byte SHALL be discarded silently, without an error.
REQ-009 In TYPE, an invalid type SHALL return the FSM to IDLE and increment err_cnt; a valid type SHALL be latched and move the FSM to HI.
REQ-010 In HI and LO, bytes SHALL be latched unconditionally; a 0xA5 byte SHALL be treated as data, with no mid-frame resync.
REQ-011 In CHK, a matching checksum SHALL commit the frame; a mismatch SHALL increment err_cnt with no output change; the FSM SHALL return to IDLE in both cases.
REQ-012 Commit SHALL take effect on the clock edge that samples the CHK byte, so outputs are visible in the next cycle (latency 1).
REQ-013 On commit:
- frame_ok SHALL pulse for exactly 1 cycle.
- KEEPER SHALL load keeper_pos = {HI,LO}[POS_W-1:0].
- SHOT SHALL load shot_pos the same way.
- CONNECT SHALL set connect_corrected=1 and pulse ack_req; the CONNECT payload is ignored.
REQ-014 The alive counter SHALL clear on every committed frame of any type and otherwise increment while connect_corrected=1.
REQ-015 When the alive counter reaches TIMEOUT_CYCLES-1, connect_corrected SHALL clear on the next edge; keeper_pos and shot_pos SHALL hold their values.
REQ-016 If a commit and the alive timeout coincide, the commit SHALL win: connect_corrected stays 1 and the counter clears.
REQ-017 Only a CONNECT frame SHALL set connect_corrected; a KEEPER or SHOT frame received while disconnected SHALL update its position output but leave connect_corrected=0.
REQ-018 Inter-byte gap: outside IDLE, GAP_CYCLES consecutive cycles without rx_valid SHALL return the FSM to IDLE and increment err_cnt once.
REQ-019 If a gap timeout and rx_valid coincide, the byte SHALL be processed and the gap counter SHALL clear.
REQ-020 err_cnt SHALL saturate at 255 and never wrap.
REQ-021 Counter widths SHALL be $clog2 of their parameter; the block SHALL contain no combinational path from inputs to outputs.

Reset
REQ-022 With rst=0 at a clk edge:
- FSM SHALL go to IDLE.
- connect_corrected, frame_ok, ack_req SHALL be 0.
- keeper_pos, shot_pos, err_cnt, and all counters and latches SHALL be 0.
REQ-023 Reset asserted mid-frame SHALL abandon the frame with no commit and no err_cnt change; the first byte after reset release SHALL be parsed from IDLE.

Verification
REQ-024 Scenario 1: bytes A5 01 00 00 01 -> next cycle connect_corrected=1, and ack_req and frame_ok each pulse for 1 cycle.
REQ-025 Scenario 2: after connect, bytes A5 02 01 2C 2F -> keeper_pos=0x12C, shot_pos unchanged, err_cnt=0.
REQ-026 Scenario 3: bytes A5 03 01 2C 00 (bad CHK) -> shot_pos unchanged, err_cnt=1, no frame_ok.
REQ-027 Scenario 4: bytes A5 07 -> err_cnt increments and FSM is in IDLE; a following valid frame commits normally.
REQ-028 Scenario 5 (TIMEOUT_CYCLES=100, GAP_CYCLES=10):
- CONNECT, then idle 100 cycles -> connect_corrected=0 exactly 100 cycles after the commit-visible cycle.
- A5 02, then idle 10 cycles -> err_cnt increments and FSM returns to IDLE.
REQ-029 Scenario 6: rst=0 while in state LO, then a full KEEPER frame -> keeper_pos holds the new value and err_cnt=0; separately, 300 bad frames -> err_cnt=255.
